acc_sequencer: RTL

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/dcim_acc_pkg.sv | 19 +
 rtl/acc_shift_core.sv | 42 ++++
 rtl/acc_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dcim_acc_pkg.sv
// Shared definitions for the bit-serial accumulation sequencer.
//   acc_state_e      : sequencer FSM states
//   DEF_INPUT_WIDTH  : default partial-sum width per bit-plane
//   DEF_OUTPUT_WIDTH : default accumulated result width
//   DEF_MAX_BITS     : default maximum bit-planes per job
package dcim_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } acc_state_e;

    localparam int DEF_INPUT_WIDTH  = 27;
    localparam int DEF_OUTPUT_WIDTH = 51;
    localparam int DEF_MAX_BITS     = 24;

endpackage

// File: rtl/acc_shift_core.sv
// Shift-accumulate datapath: acc <= (acc << 1) + psum_in, MSB plane first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the accumulator (wins over en)
//   en         : fold one partial sum into the accumulator
//   psum_in    : unsigned partial sum, zero-extended to OUTPUT_WIDTH
//   acc        : accumulator value, wraps modulo 2^OUTPUT_WIDTH
module acc_shift_core
    import dcim_acc_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [INPUT_WIDTH-1:0]  psum_in,
    output logic [OUTPUT_WIDTH-1:0] acc
);

    logic [OUTPUT_WIDTH-1:0] acc_q;
    logic [OUTPUT_WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear)
            acc_d = '0;
        else if (en)
            acc_d = (acc_q << 1) + OUTPUT_WIDTH'(psum_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/acc_sequencer.sv
// Bit-serial accumulation sequencer. Requests N bit-plane partial sums
// MSB-first, folds them through acc_shift_core and holds the result until
// the consumer accepts it.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, cfg_bits     : job request and plane count (sampled in IDLE)
//   busy                : high whenever not IDLE
//   psum_req, bit_idx   : plane request and its index (ACCUM only)
//   psum_valid, psum_in : partial-sum delivery
//   res_valid/res_ready : result handshake, res_data carries the sum
//   stall_cnt           : ACCUM cycles without psum_valid (only when
//                         ACC_SEQ_STALL_CNT_EN is defined)
module acc_sequencer
    import dcim_acc_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int MAX_BITS     = DEF_MAX_BITS,
    localparam int CBW         = $clog2(MAX_BITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CBW-1:0]          cfg_bits,
    output logic                    busy,
    output logic                    psum_req,
    output logic [CBW-1:0]          bit_idx,
    input  logic                    psum_valid,
    input  logic [INPUT_WIDTH-1:0]  psum_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUTPUT_WIDTH-1:0] res_data
`ifdef ACC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    acc_state_e     state_q, state_d;
    logic [CBW-1:0] n_q, n_d;
    logic [CBW-1:0] k_q, k_d;
    logic           core_clear;
    logic           core_en;
    logic [CBW-1:0] n_clamped;

    // Zero planes is meaningless, so it becomes one; oversize becomes MAX_BITS.
    always_comb begin
        n_clamped = cfg_bits;
        if (cfg_bits == '0)
            n_clamped = CBW'(1);
        else if (cfg_bits > CBW'(MAX_BITS))
            n_clamped = CBW'(MAX_BITS);
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        core_clear = 1'b0;
        core_en    = 1'b0;
        busy       = 1'b1;
        psum_req   = 1'b0;
        res_valid  = 1'b0;
        bit_idx    = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    n_d     = n_clamped;
                    k_d     = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                core_clear = 1'b1;
                state_d    = S_ACCUM;
            end
            S_ACCUM: begin
                psum_req = 1'b1;
                bit_idx  = n_q - CBW'(1) - k_q;
                if (psum_valid) begin
                    core_en = 1'b1;
                    k_d     = k_q + CBW'(1);
                    if (k_q + CBW'(1) == n_q)
                        state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                res_valid = 1'b1;
                // start in the handshake cycle is dropped: IDLE is only
                // reached after this edge.
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    acc_shift_core #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (core_clear),
        .en      (core_en),
        .psum_in (psum_in),
        .acc     (res_data)
    );

`ifdef ACC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start)
            stall_cnt_d = '0;
        else if (state_q == S_ACCUM && !psum_valid && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
